// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - 8-word micro-sequencer driving the register file / ALU datapath
module alu_seq_ctrl #(
    parameter int PROG_DEPTH = 8,
    parameter int IW         = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_prog_we,
    input  logic [2:0]    i_prog_addr,
    input  logic [IW-1:0] i_prog_data,
    input  logic          i_start,
    input  logic          i_step_mode,
    input  logic          i_step,
    input  logic          i_zero_in,
    output logic [2:0]    o_addr_a,
    output logic [2:0]    o_addr_b,
    output logic [2:0]    o_addr_w,
    output logic          o_reg_we,
    output logic [2:0]    o_alu_ctr,
    output logic          o_a_sel,
    output logic [2:0]    o_pc,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_PC = 4'(PROG_DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nx;
    logic [IW-1:0] r_mem [PROG_DEPTH];
    logic [IW-1:0] r_ir;
    logic [2:0]    r_pc;
    logic [2:0]    w_pc_nx;
    logic          r_zflag;
    logic          r_done;
    logic          w_done_nx;
    logic [3:0]    w_adv;
    logic [3:0]    w_pc_sum;

    // Sum is one bit wider than pc so running off the end is detected, never wrapped.
    assign w_adv    = (r_ir[14] && r_zflag) ? 4'd2 : 4'd1;
    assign w_pc_sum = {1'b0, r_pc} + w_adv;

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_done_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nx = S_FETCH;
                    w_pc_nx    = 3'd0;
                end
            end
            S_FETCH: w_state_nx = S_EXEC;
            S_EXEC:  w_state_nx = S_WB;
            S_WB: begin
                if (r_ir[15] || (w_pc_sum > LAST_PC)) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                end else begin
                    w_pc_nx    = w_pc_sum[2:0];
                    w_state_nx = i_step_mode ? S_HOLD : S_FETCH;
                end
            end
            S_HOLD: begin
                if (i_step) begin
                    w_state_nx = S_FETCH;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pc    <= 3'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_done  <= w_done_nx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ir    <= '0;
            r_zflag <= 1'b0;
        end else begin
            if (r_state == S_FETCH) begin
                r_ir <= r_mem[r_pc];
            end
            if (r_state == S_EXEC) begin
                r_zflag <= i_zero_in;
            end
        end
    end

    // Program loads are accepted only while idle so a running program cannot be altered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if ((r_state == S_IDLE) && i_prog_we) begin
            r_mem[i_prog_addr] <= i_prog_data;
        end
    end

    assign o_addr_a  = r_ir[2:0];
    assign o_addr_b  = r_ir[5:3];
    assign o_addr_w  = r_ir[8:6];
    assign o_alu_ctr = r_ir[11:9];
    assign o_a_sel   = r_ir[13];
    assign o_reg_we  = (r_state == S_WB) && r_ir[12];
    assign o_pc      = r_pc;
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed vectors and sequences for alu_seq_ctrl
module tb_alu_seq_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_prog_we = 1'b0;
    logic [2:0]  i_prog_addr = 3'd0;
    logic [15:0] i_prog_data = 16'd0;
    logic        i_start = 1'b0;
    logic        i_step_mode = 1'b0;
    logic        i_step = 1'b0;
    logic        i_zero_in = 1'b0;
    logic [2:0]  o_addr_a, o_addr_b, o_addr_w, o_alu_ctr, o_pc;
    logic        o_reg_we, o_a_sel, o_busy, o_done;

    alu_seq_ctrl #(.PROG_DEPTH(8), .IW(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr),
        .i_prog_data(i_prog_data), .i_start(i_start), .i_step_mode(i_step_mode),
        .i_step(i_step), .i_zero_in(i_zero_in), .o_addr_a(o_addr_a), .o_addr_b(o_addr_b),
        .o_addr_w(o_addr_w), .o_reg_we(o_reg_we), .o_alu_ctr(o_alu_ctr), .o_a_sel(o_a_sel),
        .o_pc(o_pc), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  a, b, w, alu;
        logic        asel, we;
    } vec_t;

    vec_t       vecs [4];
    int         checks = 0;
    int         failures = 0;
    int         nwe;
    int         done_cyc;
    logic [2:0] done_pc;
    logic       done_busy;
    logic [2:0] seen_w [8];
    logic [2:0] seen_pc [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk); i_rst = 1'b1;
        @(negedge i_clk); i_rst = 1'b0;
    endtask

    task automatic load(input logic [2:0] addr, input logic [15:0] data);
        @(negedge i_clk);
        i_prog_we = 1'b1; i_prog_addr = addr; i_prog_data = data;
        @(negedge i_clk);
        i_prog_we = 1'b0;
    endtask

    // Returns at the falling edge of cycle 1 (FETCH of the first instruction).
    task automatic pulse_start();
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
    endtask

    task automatic run_free();
        nwe = 0; done_cyc = -1; done_pc = 3'd0; done_busy = 1'b1;
        pulse_start();
        for (int c = 1; c <= 60; c++) begin
            if (o_reg_we) begin
                if (nwe < 8) begin
                    seen_w[nwe] = o_addr_w;
                    seen_pc[nwe] = o_pc;
                end
                nwe++;
            end
            if (o_done) begin
                done_cyc = c; done_pc = o_pc; done_busy = o_busy;
                break;
            end
            @(negedge i_clk);
        end
    endtask

    initial begin
        // instr encodings: halt 15, skip 14, a_sel 13, we 12, alu 11:9, w 8:6, b 5:3, a 2:0
        vecs[0] = '{16'h94D1, 3'd1, 3'd2, 3'd3, 3'd2, 1'b0, 1'b1};
        vecs[1] = '{16'hAF47, 3'd7, 3'd0, 3'd5, 3'd7, 1'b1, 1'b0};
        vecs[2] = '{16'h9238, 3'd0, 3'd7, 3'd0, 3'd1, 1'b0, 1'b1};
        vecs[3] = '{16'hB9DD, 3'd5, 3'd3, 3'd7, 3'd4, 1'b1, 1'b1};

        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_we", o_reg_we, 0);
        chk("rst_pc", o_pc, 0);
        chk("rst_fields", {o_addr_a, o_addr_b, o_addr_w, o_alu_ctr, o_a_sel}, 0);
        i_rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            do_reset();
            load(3'd0, vecs[i].instr);
            pulse_start();
            chk($sformatf("v%0d_c1_busy", i), o_busy, 1);
            chk($sformatf("v%0d_c1_we", i), o_reg_we, 0);
            @(negedge i_clk);
            @(negedge i_clk);
            chk($sformatf("v%0d_we", i), o_reg_we, vecs[i].we);
            chk($sformatf("v%0d_a", i), o_addr_a, vecs[i].a);
            chk($sformatf("v%0d_b", i), o_addr_b, vecs[i].b);
            chk($sformatf("v%0d_w", i), o_addr_w, vecs[i].w);
            chk($sformatf("v%0d_alu", i), o_alu_ctr, vecs[i].alu);
            chk($sformatf("v%0d_asel", i), o_a_sel, vecs[i].asel);
            chk($sformatf("v%0d_c3_done", i), o_done, 0);
            @(negedge i_clk);
            chk($sformatf("v%0d_c4_done", i), o_done, 1);
            chk($sformatf("v%0d_c4_busy", i), o_busy, 0);
            chk($sformatf("v%0d_c4_we", i), o_reg_we, 0);
            @(negedge i_clk);
            chk($sformatf("v%0d_c5_done", i), o_done, 0);
        end

        // Eight plain write instructions, addr_w = word index.
        do_reset();
        for (int i = 0; i < 8; i++) load(3'(i), 16'h1000 | 16'(i << 6));
        run_free();
        chk("fill_nwe", nwe, 8);
        chk("fill_done_cyc", done_cyc, 25);
        chk("fill_pc", done_pc, 7);
        chk("fill_busy", done_busy, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill_pc%0d", i), seen_pc[i], i);
            chk($sformatf("fill_w%0d", i), seen_w[i], i);
        end

        // Skip on words 2 and 6 with zero_in held high: 0,1,2,4,5,6 then done.
        load(3'd2, 16'h5080);
        load(3'd6, 16'h5180);
        i_zero_in = 1'b1;
        run_free();
        chk("skip_nwe", nwe, 6);
        chk("skip_done_cyc", done_cyc, 19);
        chk("skip_pc", done_pc, 6);
        chk("skip_w2", seen_w[2], 2);
        chk("skip_w3", seen_w[3], 4);
        chk("skip_pc3", seen_pc[3], 4);
        chk("skip_w5", seen_w[5], 6);

        i_zero_in = 1'b0;
        run_free();
        chk("noskip_nwe", nwe, 8);
        chk("noskip_done_cyc", done_cyc, 25);
        chk("noskip_w3", seen_w[3], 3);

        // Program writes while busy must be ignored.
        pulse_start();
        i_prog_we = 1'b1; i_prog_addr = 3'd5; i_prog_data = 16'h8000;
        for (int c = 0; c < 5; c++) @(negedge i_clk);
        i_prog_we = 1'b0;
        done_cyc = -1;
        for (int c = 0; c < 60; c++) begin
            if (o_done) begin done_cyc = c; break; end
            @(negedge i_clk);
        end
        chk("busywr_finished", done_cyc >= 0, 1);
        run_free();
        chk("busywr_nwe", nwe, 8);
        chk("busywr_w5", seen_w[5], 5);

        // Single-step: words 0..2, word 2 halts.
        do_reset();
        load(3'd0, 16'h1000);
        load(3'd1, 16'h1040);
        load(3'd2, 16'h9080);
        i_step_mode = 1'b1;
        pulse_start();
        @(negedge i_clk);
        @(negedge i_clk);
        chk("step_wb0_we", o_reg_we, 1);
        @(negedge i_clk);
        chk("step_hold_busy", o_busy, 1);
        chk("step_hold_we", o_reg_we, 0);
        chk("step_hold_pc", o_pc, 1);
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        chk("step_start_pc", o_pc, 1);
        chk("step_start_busy", o_busy, 1);
        chk("step_start_we", o_reg_we, 0);
        for (int k = 1; k <= 2; k++) begin
            i_step = 1'b1;
            @(negedge i_clk);
            i_step = 1'b0;
            @(negedge i_clk);
            @(negedge i_clk);
            chk($sformatf("step%0d_we", k), o_reg_we, 1);
            chk($sformatf("step%0d_w", k), o_addr_w, k);
            @(negedge i_clk);
            if (k == 1) begin
                chk("step1_hold_pc", o_pc, 2);
                chk("step1_hold_busy", o_busy, 1);
            end else begin
                chk("step2_done", o_done, 1);
                chk("step2_busy", o_busy, 0);
            end
        end
        i_step_mode = 1'b0;

        // Write and start in the same idle cycle: FETCH sees the new word.
        do_reset();
        @(negedge i_clk);
        i_prog_we = 1'b1; i_prog_addr = 3'd0; i_prog_data = 16'h94D1; i_start = 1'b1;
        @(negedge i_clk);
        i_prog_we = 1'b0; i_start = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("same_we", o_reg_we, 1);
        chk("same_w", o_addr_w, 3);
        @(negedge i_clk);
        chk("same_done", o_done, 1);

        // Reset during the WB of word 1.
        do_reset();
        for (int i = 0; i < 8; i++) load(3'(i), 16'h1000 | 16'(i << 6));
        pulse_start();
        for (int c = 0; c < 5; c++) @(negedge i_clk);
        chk("rstwb_we_before", o_reg_we, 1);
        chk("rstwb_w_before", o_addr_w, 1);
        i_rst = 1'b1;
        #1;
        chk("rstwb_we", o_reg_we, 0);
        chk("rstwb_busy", o_busy, 0);
        chk("rstwb_pc", o_pc, 0);
        chk("rstwb_done", o_done, 0);
        chk("rstwb_w", o_addr_w, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        run_free();
        chk("rstwb_nwe", nwe, 0);
        chk("rstwb_done_cyc", done_cyc, 25);
        chk("rstwb_pc_end", done_pc, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
